// File: rtl/ram_sp_pkg.sv
// Shared definitions for the single-port byte-enable RAM: read-during-write modes,
// sequencer states and the byte-lane helper.
package ram_sp_pkg;

  localparam int unsigned WR_READ_FIRST  = 0;
  localparam int unsigned WR_WRITE_FIRST = 1;
  localparam int unsigned WR_NO_CHANGE   = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  function automatic int unsigned lane_cnt(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ram_sp_clear_seq.sv
// Power-on clear sequencer: sweeps every address once with a zero-write strobe,
// then parks in RUN with rdy high until the next reset.
module ram_sp_clear_seq
  import ram_sp_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rdy,
  output logic [ADDR_W-1:0] clr_a,
  output logic              clr_we
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter stops at the last address so the sweep never wraps into a second pass.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    rdy     = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == '1) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        rdy = 1'b1;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign clr_a = cnt_q;

endmodule

// File: rtl/ram_sp_sync_be.sv
// Single-port synchronous RAM with byte write enables, selectable read-during-write
// mode and self-clearing sweep. Define RAM_SP_OUT_REG_EN for an extra output register.
module ram_sp_sync_be
  import ram_sp_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 6,
  parameter int unsigned WR_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [lane_cnt(DATA_W)-1:0] we,
  input  logic [ADDR_W-1:0]           a,
  input  logic [DATA_W-1:0]           di,
  output logic                        rdy,
  output logic [DATA_W-1:0]           dout,
  output logic                        dout_vld
);

  localparam int unsigned LANES = lane_cnt(DATA_W);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (WR_MODE > WR_NO_CHANGE) begin : g_bad_mode
    $error("ram_sp_sync_be: WR_MODE must be 0, 1 or 2");
  end
  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("ram_sp_sync_be: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_a;
  logic              acc;
  logic [ADDR_W-1:0] port_a;
  logic [DATA_W-1:0] port_d;
  logic [LANES-1:0]  port_be;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] merged;
  logic [DATA_W-1:0] s1_d;
  logic              s1_v;

  ram_sp_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clear_seq (
    .clk    (clk),
    .rst    (rst),
    .rdy    (rdy),
    .clr_a  (clr_a),
    .clr_we (clr_we)
  );

  assign acc = rdy & en;

  // The sweep owns the write port while clearing; rdy gates user requests off meanwhile.
  always_comb begin
    port_a  = a;
    port_d  = di;
    port_be = '0;
    if (clr_we) begin
      port_a  = clr_a;
      port_d  = '0;
      port_be = '1;
    end else if (acc) begin
      port_be = we;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (port_be[i]) begin
        mem[port_a][8*i +: 8] <= port_d[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[a];
    merged  = rd_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (we[i]) begin
        merged[8*i +: 8] = di[8*i +: 8];
      end
    end
  end

  // Capturing rd_word at the edge yields the pre-write word; merged is the post-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_d <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_v <= acc;
      if (acc) begin
        if (WR_MODE == WR_WRITE_FIRST) begin
          s1_d <= merged;
        end else if (WR_MODE == WR_NO_CHANGE) begin
          if (we == '0) begin
            s1_d <= rd_word;
          end
        end else begin
          s1_d <= rd_word;
        end
      end
    end
  end

`ifdef RAM_SP_OUT_REG_EN
  logic [DATA_W-1:0] s2_d;
  logic              s2_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_d <= '0;
      s2_v <= 1'b0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_d <= s1_d;
      end
    end
  end

  assign dout     = s2_d;
  assign dout_vld = s2_v;
`else
  assign dout     = s1_d;
  assign dout_vld = s1_v;
`endif

endmodule

// File: tb/tb_ram_sp_sync_be.sv
// Bench for ram_sp_sync_be: three instances (one per read-during-write mode) share
// the same stimulus and are compared against a behavioural memory model.
module tb_ram_sp_sync_be;
  import ram_sp_pkg::*;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 64;
`ifdef RAM_SP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [1:0]  we  = '0;
  logic [5:0]  a   = '0;
  logic [15:0] di  = '0;

  logic [2:0]  rdy_v;
  logic [2:0]  vld_v;
  logic [15:0] dout_v [3];

  for (genvar m = 0; m < 3; m++) begin : g_dut
    ram_sp_sync_be #(
      .DATA_W  (DW),
      .ADDR_W  (AW),
      .WR_MODE (m)
    ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .we       (we),
      .a        (a),
      .di       (di),
      .rdy      (rdy_v[m]),
      .dout     (dout_v[m]),
      .dout_vld (vld_v[m])
    );
  end

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [15:0] d2;
  } ent_t;

  logic [15:0] mm [DEPTH];
  ent_t        pipe [$];
  logic [15:0] exp_d [3];
  logic        exp_v;
  logic [15:0] nc_prev;
  int          clr_left;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    pipe.delete();
    for (int i = 0; i < LAT - 1; i++) pipe.push_back('0);
    for (int i = 0; i < 3; i++) exp_d[i] = '0;
    exp_v    = 1'b0;
    nc_prev  = '0;
    clr_left = DEPTH;
    // After any reset the sweep leaves the whole memory zero before the first access.
    for (int i = 0; i < int'(DEPTH); i++) mm[i] = '0;
  endtask

  task automatic model_edge(input logic e, input logic [1:0] w, input logic [5:0] ad,
                            input logic [15:0] d);
    ent_t        ne;
    ent_t        out;
    logic [15:0] old;
    logic [15:0] mg;
    if (rst) begin
      clr_left = DEPTH;
      return;
    end
    ne = '0;
    if (e && clr_left == 0) begin
      old = mm[ad];
      mg  = old;
      if (w[0]) mg[7:0]  = d[7:0];
      if (w[1]) mg[15:8] = d[15:8];
      ne.v  = 1'b1;
      ne.d0 = old;
      ne.d1 = mg;
      ne.d2 = (w == 2'b00) ? old : nc_prev;
      nc_prev = ne.d2;
      mm[ad]  = mg;
    end
    if (clr_left > 0) clr_left--;
    pipe.push_back(ne);
    out   = pipe.pop_front();
    exp_v = out.v;
    if (out.v) begin
      exp_d[0] = out.d0;
      exp_d[1] = out.d1;
      exp_d[2] = out.d2;
    end
  endtask

  task automatic check_outs(input string tag);
    for (int m = 0; m < 3; m++) begin
      check_eq($sformatf("%s.rdy%0d", tag, m), 32'(rdy_v[m]), 32'(clr_left == 0));
      check_eq($sformatf("%s.vld%0d", tag, m), 32'(vld_v[m]), 32'(exp_v));
      check_eq($sformatf("%s.dout%0d", tag, m), 32'(dout_v[m]), 32'(exp_d[m]));
    end
  endtask

  task automatic step(input logic e, input logic [1:0] w, input logic [5:0] ad,
                      input logic [15:0] d, input string tag);
    en = e; we = w; a = ad; di = d;
    @(posedge clk);
    model_edge(e, w, ad, d);
    #1;
    check_outs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 6'($urandom), 16'($urandom), tag);
  endtask

  task automatic rand_step(input string tag);
    step(1'($urandom), 2'($urandom), 6'($urandom), 16'($urandom), tag);
  endtask

  task automatic pulse_reset(input int n);
    rst = 1'b1;
    model_reset();
    #1;
    check_outs("rst_async");
    for (int i = 0; i < n; i++) rand_step("rst_hold");
    rst = 1'b0;
  endtask

  task automatic run_sweep();
    for (int i = 0; i < int'(DEPTH) + 4 && clr_left != 0; i++) rand_step("sweep");
  endtask

  initial begin
    model_reset();
    pulse_reset(3);

    // Request during CLEAR must be ignored.
    step(1'b1, 2'b11, 6'd3, 16'hFFFF, "clr_req");
    run_sweep();

    step(1'b1, 2'b00, 6'd0,  '0, "rd0");
    step(1'b1, 2'b00, 6'd31, '0, "rd31");
    step(1'b1, 2'b00, 6'd63, '0, "rd63");
    step(1'b1, 2'b00, 6'd3,  '0, "rd3");
    idle(LAT, "idle");

    step(1'b1, 2'b11, 6'd5, 16'hBEEF, "wr5");
    step(1'b1, 2'b10, 6'd5, 16'h1234, "wr5_hi");
    step(1'b1, 2'b00, 6'd5, '0, "rd5");
    idle(LAT - 1, "lat");
    for (int m = 0; m < 3; m++) check_eq($sformatf("merge5.%0d", m), 32'(dout_v[m]), 32'h12EF);

    step(1'b1, 2'b11, 6'd9, 16'h5555, "wr9");
    step(1'b1, 2'b00, 6'd5, '0, "rd5b");
    step(1'b1, 2'b11, 6'd9, 16'hAAAA, "rdw9");
    idle(LAT - 1, "lat");
    check_eq("rdw.read_first",  32'(dout_v[0]), 32'h5555);
    check_eq("rdw.write_first", 32'(dout_v[1]), 32'hAAAA);
    check_eq("rdw.no_change",   32'(dout_v[2]), 32'h12EF);
    step(1'b1, 2'b00, 6'd9, '0, "rd9");
    idle(LAT, "idle");

    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 2'b11, 6'(i), 16'(i), "preload");
    for (int i = 0; i < int'(DEPTH); i++) step(1'b1, 2'b00, 6'(i), '0, "stream");
    idle(LAT + 1, "idle");

    step(1'b1, 2'b11, 6'd50, 16'h1234, "wr50");
    pulse_reset(2);
    for (int i = 0; i < 40; i++) rand_step("sweep40");
    pulse_reset(1);
    run_sweep();
    step(1'b1, 2'b00, 6'd50, '0, "rd50");
    idle(LAT - 1, "lat");
    for (int m = 0; m < 3; m++) check_eq($sformatf("clr50.%0d", m), 32'(dout_v[m]), 32'h0);

    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        pulse_reset(1);
        run_sweep();
      end
      step(($urandom_range(0, 3) != 0), 2'($urandom), 6'($urandom_range(0, 7)),
           16'($urandom), "rand");
    end
    idle(LAT + 1, "tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sp_sync_be.md
# ram_sp_sync_be

Parametrised single-port block RAM with synchronous (read-through) read, per-byte write enables, selectable read-during-write mode and a self-clearing initialisation sequencer. It is the general-purpose successor to the fixed 64x16 read-through RAM and maps onto one or more block RAM primitives. It sits behind any single-master datapath that needs an addressable scratch store and a known-zero memory after reset.

## Interface
- DATA_W, 16: word width in bits; must be a multiple of 8.
- ADDR_W, 6: address width; DEPTH = 2**ADDR_W words.
- WR_MODE, 0: read-during-write behaviour; 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  access request; sampled only when rdy=1.
- we  in  DATA_W/8  byte write enables; lane i covers di[8i+7:8i]; all-zero = read.
- a  in  ADDR_W  word address.
- di  in  DATA_W  write data.
- rdy  out  1  high when the RAM accepts requests; low during the clear sweep.
- dout  out  DATA_W  read data.
- dout_vld  out  1  one-cycle pulse marking valid dout for an accepted request.

## Operation
- States: CLEAR, RUN. Reset enters CLEAR with the sweep counter at 0.
- CLEAR: writes all-zero words to address counter 0..DEPTH-1, one per cycle. en, we, a and di are ignored. After writing DEPTH-1, the block moves to RUN. rdy=0 throughout CLEAR.
- RUN: rdy=1. An accepted request is en=1 on a rising edge.
- Write: only lanes with we[i]=1 are updated. Other lanes keep their contents.
- Read: the address is registered, and dout = mem[registered address].
- Read-during-write (we≠0), by WR_MODE:
  - READ_FIRST: dout shows the pre-write word.
  - WRITE_FIRST: dout shows the merged post-write word.
  - NO_CHANGE: dout holds its previous value, but dout_vld still pulses.
- en=0: dout holds its value and dout_vld stays 0.
- Reset values: rdy=0, dout=0, dout_vld=0, sweep counter=0, state=CLEAR. Array contents are not reset directly; the CLEAR sweep zeroes them.
- Reset asserted mid-sweep or mid-RUN aborts any in-flight request, drops dout_vld, and restarts CLEAR from address 0.
- Illegal WR_MODE (>2) is a generation-time error.

## Timing
- Clear sweep: rdy rises on the edge DEPTH cycles after the first rising clk edge with rst low. With defaults this is 64 cycles.
- Read latency: 1 cycle. A request accepted at edge N gives dout and dout_vld=1 after edge N+1.
- Requests may be issued back-to-back every cycle. Throughput is 1 access/cycle.
- Address counter wrap: the sweep ends exactly at DEPTH-1 and never wraps into a second pass.
- An access to the address written on the previous cycle returns the newly written data in every mode.

## Configuration
- RAM_SP_OUT_REG_EN defined: adds an output register after the array stage, mapping to the primitive's output register.
  - Read latency becomes 2 cycles. dout_vld is delayed by the same amount.
  - The output register resets to 0.
  - NO_CHANGE holds apply at the output register.
- RAM_SP_OUT_REG_EN undefined: single-stage read, latency 1, as described above.

## Structure
- Shared package ram_sp_pkg holds:
  - WR_MODE constants: WR_READ_FIRST=0, WR_WRITE_FIRST=1, WR_NO_CHANGE=2.
  - The state encoding: CLEAR, RUN.
  - A byte-lane count function: DATA_W/8.
- One sub-module, ram_sp_clear_seq, holds the CLEAR/RUN state register, sweep counter and rdy. It outputs the sweep address and a sweep write strobe, which the top muxes onto the array port.
- The array, registered address, output path and dout_vld pipeline live in the top module.

## Test plan
- Reset then idle, defaults: rdy=0 for 64 cycles, then 1. Reading addresses 0, 31 and 63 returns 0x0000, each with dout_vld one cycle after request.
- Write 0xBEEF to addr 5 with we=2'b11, then write 0x12xx with we=2'b10: a read of addr 5 returns 0x12EF.
- Same-cycle write 0xAAAA over existing 0x5555 at addr 9:
  - READ_FIRST gives dout=0x5555.
  - WRITE_FIRST gives 0xAAAA.
  - NO_CHANGE holds the prior dout.
  - dout_vld=1 in all three modes.
- Back-to-back reads of addrs 0..63 after preloading data=addr: dout streams 0..63 with dout_vld continuously high. With RAM_SP_OUT_REG_EN, the stream is shifted by one extra cycle.
- Assert rst at sweep address 40, then release: rdy stays low for a full 64 further cycles, and addr 50 (written before reset) reads 0x0000.
- Requests during CLEAR, e.g. en=1, we=2'b11, a=3, di=0xFFFF: ignored, no dout_vld, and addr 3 reads 0x0000 after rdy.
